// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: grant, registered operands, captured result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic [WIDTH-1:0]      alu_src_a,
  output logic [WIDTH-1:0]      alu_src_b,
  output logic [1:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_gnt;
  logic             w_any;
  logic             w_accept;

  assign w_any    = |req_valid;
  assign w_accept = (r_state == S_IDLE) && w_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_gnt = IW'(i);
    end
  end
`else
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic          w_hit;

  // Search starts just past the last winner and wraps back to it.
  always_comb begin
    w_gnt = r_last;
    w_idx = r_last;
    w_hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_hit && req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= IW'(NREQ - 1);
    end else if (w_accept) begin
      r_last <= w_gnt;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (rsp_ready[r_owner]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_owner  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= req_a[int'(w_gnt)*WIDTH +: WIDTH];
        r_b     <= req_b[int'(w_gnt)*WIDTH +: WIDTH];
        r_op    <= req_op[int'(w_gnt)*2 +: 2];
        r_owner <= w_gnt;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
    end
  end

  // reset_n gating keeps req_ready low while reset is held with requests pending.
  assign req_ready  = (reset_n && w_accept) ? (NREQ'(1) << w_gnt) : '0;
  assign rsp_valid  = (r_state == S_RESP) ? (NREQ'(1) << r_owner) : '0;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign alu_src_a  = r_a;
  assign alu_src_b  = r_b;
  assign alu_ctrl   = r_op;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed steps plus random requests against a reference model.
// Build with ALU_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic [W-1:0] alu_src_a;
  logic [W-1:0] alu_src_b;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         busy;

  int n_vec  = 0;
  int n_miss = 0;
  int m_last = N - 1;

  alu_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stand-in ALU driven by the arbiter
  always_comb begin
    alu_result = ref_res(alu_src_a, alu_src_b, alu_ctrl);
    alu_zero   = (alu_result == '0);
  end

  // Expected winner among the valid requesters
  function automatic int pick(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    int first;
    first = (m_last + 1) % N;
    return v[first] ? first : (first + 1) % N;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [1:0] vm,
                     input logic [31:0] a0, input logic [31:0] b0,
                     input logic [1:0] o0,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input logic [1:0] o1,
                     input int hold, input bit drop);
    int g;
    logic [31:0] ga;
    logic [31:0] gb;
    logic [1:0]  go;
    logic [31:0] er;
    logic [1:0]  oh;
    req_valid = vm;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_op    = {o1, o0};
    rsp_ready = '0;
    #1;
    if (vm == 2'b00) begin
      chk("idle_no_ready", req_ready, 2'b00);
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      return;
    end
    g  = pick(vm);
    oh = 2'(1 << g);
    ga = (g == 1) ? a1 : a0;
    gb = (g == 1) ? b1 : b0;
    go = (g == 1) ? o1 : o0;
    er = ref_res(ga, gb, go);
    chk("grant", req_ready, oh);
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);
    m_last = g;
    chk("exec_busy", busy, 1'b1);
    chk("exec_ready", req_ready, 2'b00);
    chk("exec_src_a", alu_src_a, ga);
    chk("exec_src_b", alu_src_b, gb);
    chk("exec_ctrl", alu_ctrl, go);
    req_a  = {$urandom, $urandom};
    req_b  = {$urandom, $urandom};
    req_op = 4'($urandom);
    if (drop) req_valid = '0;
    #1;
    chk("exec_src_a_held", alu_src_a, ga);
    chk("exec_src_b_held", alu_src_b, gb);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_result", rsp_result, er);
      chk("rsp_zero", rsp_zero, er == 32'd0);
      chk("rsp_ready_block", req_ready, 2'b00);
      chk("rsp_busy", busy, 1'b1);
      if (i < hold) begin
        rsp_ready = ~oh;
        @(negedge clk);
      end
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    chk("ret_busy", busy, 1'b0);
    chk("ret_rsp_valid", rsp_valid, 2'b00);
    chk("ret_result_held", rsp_result, er);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", rsp_zero, 1'b0);
    chk("rst_ctrl", alu_ctrl, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    txn(2'b01, 32'd5, 32'd7, 2'b00, 32'd0, 32'd0, 2'b00, 0, 1'b1);
    txn(2'b10, 32'd0, 32'd0, 2'b00, 32'd9, 32'd9, 2'b01, 0, 1'b1);
    txn(2'b10, 32'd0, 32'd0, 2'b00, 32'hF0F0_00FF, 32'h0FF0_F00F,
        2'b10, 0, 1'b1);
    chk("and_value", rsp_result, 32'h00F0_000F);

    // Both requesters hold valid through back-to-back operations
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, $urandom, $urandom, 2'($urandom),
          $urandom, $urandom, 2'($urandom), (i == 1) ? 5 : 0, 1'b0);
    end

    // Reset in the middle of an operation owned by requester 0
    req_valid = 2'b01;
    req_a     = {32'd0, 32'd3};
    req_b     = {32'd0, 32'd4};
    req_op    = 4'b0000;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    req_valid = 2'b11;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 2'b00);
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_zero", rsp_zero, 1'b0);
    chk("mid_rst_ctrl", alu_ctrl, 2'b00);
    chk("mid_rst_src_a", alu_src_a, 32'd0);
    m_last = N - 1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ptr_after_reset", req_ready, 2'b01);
    txn(2'b11, 32'd1, 32'd2, 2'b11, 32'd8, 32'd4, 2'b01, 0, 1'b1);
    txn(2'b10, 32'd0, 32'd0, 2'b00, 32'd20, 32'd22, 2'b00, 1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      txn(2'($urandom), ra, rb, 2'($urandom),
          rb, ra, 2'($urandom), $urandom_range(0, 3),
          1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
